hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Parametrised load-use hazard and stall controller for the 5-stage pipeline. It compares NRD decode-stage source registers against a load in EX. On a match it stalls PC and IF/ID and injects a bubble into ID/EX for a configurable number of cycles. It also freezes the whole pipeline while data memory is busy, lets a branch flush cancel an in-progress stall, and keeps a saturating count of load-use stall cycles for performance analysis.

Parameters:
AW, 4, register address width
NRD, 2, number of decode-stage source read ports checked
LOAD_STALL, 1, stall cycles per load-use hazard (1..7)
ZERO_REG_HW, 1, when 1, register 0 is hardwired and never causes a hazard
CNTW, 16, width of the stall statistics counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
d_valid  in  1  decode stage holds a valid instruction
d_raddr  in  NRD*AW  source register addresses; port i at bits [i*AW +: AW]
d_ren  in  NRD  per-port "really reads register" mask (immediate-only/lhb/jr/exec decoding is done upstream)
e_valid  in  1  EX stage holds a valid instruction
e_isLoad  in  1  EX instruction is a load
e_wreg  in  AW  EX destination register
mem_busy  in  1  data memory access not complete (replaces write_done: busy = !done)
flush  in  1  branch/jump resolved taken; younger instructions squashed
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
idex_stall  out  1  hold ID/EX register contents
idex_bubble  out  1  load NOP into ID/EX
exmem_stall  out  1  hold EX/MEM and MEM/WB
hazard_vec  out  NRD  per-port match of the current hazard (combinational)
stall_cycles  out  CNTW  saturating count of load-use stall cycles

Behaviour:
- Match: hit[i] = d_ren[i] & (d_raddr[i] == e_wreg). hazard_vec = hit when e_valid & e_isLoad & d_valid, else 0.
- If ZERO_REG_HW=1 and e_wreg==0, then hazard_vec=0.
- lu_hz = |hazard_vec.
- States: IDLE, LU_STALL. Counter cnt is 3 bits.
- Priority, highest first: rst > mem_busy > flush > LU_STALL > lu_hz.
- rst (async): state=IDLE, cnt=0, stall_cycles=0. While rst is high, all stall/bubble outputs are 0 and hazard_vec=0.
- mem_busy=1: pc_stall = ifid_stall = idex_stall = exmem_stall = 1 and idex_bubble=0. State, cnt and stall_cycles are frozen and no hazard is newly registered.
- flush=1 (mem_busy=0): state goes to IDLE next cycle, cnt=0. All outputs are 0 in that cycle, so the PC takes the target and the flushing logic owns IF/ID and ID/EX. A hazard present in the same cycle is ignored.
- IDLE with lu_hz=1: pc_stall = ifid_stall = idex_bubble = 1 in the same cycle (combinational, zero latency). stall_cycles increments.
  - If LOAD_STALL>1: go to LU_STALL with cnt = LOAD_STALL-1.
  - If LOAD_STALL=1: stay in IDLE.
- LU_STALL: pc_stall = ifid_stall = idex_bubble = 1 regardless of lu_hz. Each cycle cnt decrements and stall_cycles increments. When cnt==1, return to IDLE next cycle.
- Total stall per hazard is exactly LOAD_STALL cycles. On returning to IDLE, the hazard is re-evaluated normally: the load has left EX, so no double count.
- idex_stall and exmem_stall are 1 only under mem_busy. idex_stall and idex_bubble are never both 1.
- stall_cycles saturates at all ones and does not wrap.
- X-safety: d_valid/e_valid/e_isLoad that are not 1'b1 are treated as 0. Unknown inputs never produce a sticky stall; no output feeds back combinationally.

Test Plan:
1. Default params. Load r3 in EX; decode reads r3 on port 1 (d_ren=2'b10). Result: same cycle pc_stall = ifid_stall = idex_bubble = 1 and hazard_vec=2'b10; next cycle all outputs are 0; stall_cycles=1.
2. Load to r0 with ZERO_REG_HW=1 and decode reading r0 → no stall, hazard_vec=0. Same with a matching address but d_ren=0 → no stall.
3. LOAD_STALL=3, hazard. Result: stall outputs high for exactly 3 cycles, state returns to IDLE, stall_cycles=3.
4. LOAD_STALL=3, raise mem_busy for 2 cycles during LU_STALL. Result: all four *_stall outputs are 1, idex_bubble=0, cnt is frozen; the load-use stall resumes afterwards, totalling 3 bubble cycles plus 2 freeze cycles.
5. flush asserted in the second LU_STALL cycle. Result: outputs 0 that cycle, IDLE next cycle, stall_cycles stays at 2. Also check flush and lu_hz in the same cycle → no stall.
6. CNTW=4 with 20 consecutive hazards → stall_cycles holds 15. Assert rst mid-LU_STALL → outputs go to 0 immediately and the counter clears.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector and pipeline stall controller for the 5-stage pipeline.
// Stall/bubble outputs are combinational so a hazard stalls in the cycle it is seen.
module hazard_stall_ctrl #(
  parameter int AW          = 4,
  parameter int NRD         = 2,
  parameter int LOAD_STALL  = 1,
  parameter int ZERO_REG_HW = 1,
  parameter int CNTW        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_valid,
  input  logic [NRD*AW-1:0]   d_raddr,
  input  logic [NRD-1:0]      d_ren,
  input  logic                e_valid,
  input  logic                e_isLoad,
  input  logic [AW-1:0]       e_wreg,
  input  logic                mem_busy,
  input  logic                flush,
  output logic                pc_stall,
  output logic                ifid_stall,
  output logic                idex_stall,
  output logic                idex_bubble,
  output logic                exmem_stall,
  output logic [NRD-1:0]      hazard_vec,
  output logic [CNTW-1:0]     stall_cycles
);

  typedef enum logic {IDLE, LU_STALL} state_t;

  state_t         state;
  logic [2:0]     cnt;
  logic [NRD-1:0] hit;
  logic           zero_dst;
  logic           lu_hz;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      hit[i] = d_ren[i] && (d_raddr[i*AW +: AW] == e_wreg);
    end
  end

  assign zero_dst = (ZERO_REG_HW != 0) && (e_wreg == '0);

  // if() on an unknown condition falls through, so X qualifiers never raise a hazard
  always_comb begin
    hazard_vec = '0;
    if (!rst && d_valid && e_valid && e_isLoad && !zero_dst) begin
      hazard_vec = hit;
    end
  end

  assign lu_hz = |hazard_vec;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    exmem_stall = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (mem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
    end else if (flush) begin
      pc_stall = 1'b0;
    end else if (state == LU_STALL || lu_hz) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      stall_cycles <= '0;
    end else if (mem_busy) begin
      state        <= state;
      cnt          <= cnt;
      stall_cycles <= stall_cycles;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == LU_STALL) begin
      if (stall_cycles != '1) stall_cycles <= stall_cycles + CNTW'(1);
      if (cnt == 3'd1) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end else if (lu_hz) begin
      if (stall_cycles != '1) stall_cycles <= stall_cycles + CNTW'(1);
      // the detecting cycle is the first stall cycle, so only LOAD_STALL-1 remain
      if (LOAD_STALL > 1) begin
        state <= LU_STALL;
        cnt   <= 3'(LOAD_STALL - 1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: three configurations share one stimulus
// stream; a bubble-debt reference model predicts every output each cycle.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_valid = 1'b0;
  logic [7:0] d_raddr = '0;
  logic [1:0] d_ren = '0;
  logic       e_valid = 1'b0;
  logic       e_isLoad = 1'b0;
  logic [3:0] e_wreg = '0;
  logic       mem_busy = 1'b0;
  logic       flush = 1'b0;

  logic [2:0]  pc_s, ifid_s, idex_s, bub_s, exm_s;
  logic [1:0]  hv0, hv1, hv2;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.AW(4), .NRD(2), .LOAD_STALL(1), .ZERO_REG_HW(1), .CNTW(16)) dut_a (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_raddr(d_raddr), .d_ren(d_ren),
    .e_valid(e_valid), .e_isLoad(e_isLoad), .e_wreg(e_wreg), .mem_busy(mem_busy),
    .flush(flush), .pc_stall(pc_s[0]), .ifid_stall(ifid_s[0]), .idex_stall(idex_s[0]),
    .idex_bubble(bub_s[0]), .exmem_stall(exm_s[0]), .hazard_vec(hv0), .stall_cycles(sc0));

  hazard_stall_ctrl #(.AW(4), .NRD(2), .LOAD_STALL(3), .ZERO_REG_HW(1), .CNTW(16)) dut_b (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_raddr(d_raddr), .d_ren(d_ren),
    .e_valid(e_valid), .e_isLoad(e_isLoad), .e_wreg(e_wreg), .mem_busy(mem_busy),
    .flush(flush), .pc_stall(pc_s[1]), .ifid_stall(ifid_s[1]), .idex_stall(idex_s[1]),
    .idex_bubble(bub_s[1]), .exmem_stall(exm_s[1]), .hazard_vec(hv1), .stall_cycles(sc1));

  hazard_stall_ctrl #(.AW(4), .NRD(2), .LOAD_STALL(2), .ZERO_REG_HW(0), .CNTW(4)) dut_c (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_raddr(d_raddr), .d_ren(d_ren),
    .e_valid(e_valid), .e_isLoad(e_isLoad), .e_wreg(e_wreg), .mem_busy(mem_busy),
    .flush(flush), .pc_stall(pc_s[2]), .ifid_stall(ifid_s[2]), .idex_stall(idex_s[2]),
    .idex_bubble(bub_s[2]), .exmem_stall(exm_s[2]), .hazard_vec(hv2), .stall_cycles(sc2));

  typedef struct packed {
    logic        pc;
    logic        ifid;
    logic        idex;
    logic        bub;
    logic        exm;
    logic [1:0]  hv;
    logic [15:0] sc;
  } exp_t;
  typedef exp_t [2:0] exp3_t;

  exp3_t sb[$];

  int ls[3]   = '{1, 3, 2};
  int zhw[3]  = '{1, 1, 0};
  int cmax[3] = '{65535, 65535, 15};
  int owed[3] = '{0, 0, 0};
  int count[3] = '{0, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp_v);
    end
  endtask

  // Model: each hazard creates a debt of LOAD_STALL bubble cycles, paid one per
  // unfrozen cycle; flush cancels the debt, mem_busy freezes everything.
  task automatic drive(input logic r, input logic dv, input logic [7:0] ra, input logic [1:0] rn,
                       input logic ev, input logic el, input logic [3:0] wr,
                       input logic mb, input logic fl);
    exp3_t e;
    logic [1:0] h;
    @(posedge clk);
    #1;
    rst = r; d_valid = dv; d_raddr = ra; d_ren = rn;
    e_valid = ev; e_isLoad = el; e_wreg = wr; mem_busy = mb; flush = fl;
    for (int k = 0; k < 3; k++) begin
      e[k] = '0;
      h = '0;
      if (dv && ev && el && !(zhw[k] != 0 && wr == 4'd0)) begin
        for (int p = 0; p < 2; p++) h[p] = rn[p] && (ra[p*4 +: 4] == wr);
      end
      if (r) begin
        owed[k] = 0;
        count[k] = 0;
      end else begin
        e[k].hv = h;
        e[k].sc = 16'(count[k]);
        if (mb) begin
          e[k].pc = 1'b1; e[k].ifid = 1'b1; e[k].idex = 1'b1; e[k].exm = 1'b1;
        end else if (fl) begin
          owed[k] = 0;
        end else if (owed[k] > 0 || h != 2'b00) begin
          e[k].pc = 1'b1; e[k].ifid = 1'b1; e[k].bub = 1'b1;
          if (count[k] < cmax[k]) count[k]++;
          owed[k] = (owed[k] > 0) ? owed[k] - 1 : ls[k] - 1;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic hz3(input logic mb, input logic fl);
    drive(1'b0, 1'b1, 8'h35, 2'b10, 1'b1, 1'b1, 4'd3, mb, fl);
  endtask

  initial begin : monitor
    exp3_t e;
    logic [15:0] sc_act;
    logic [1:0]  hv_act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          sc_act = (k == 0) ? sc0 : (k == 1) ? sc1 : {12'b0, sc2};
          hv_act = (k == 0) ? hv0 : (k == 1) ? hv1 : hv2;
          chk("pc_stall",     k, 32'(pc_s[k]),   32'(e[k].pc));
          chk("ifid_stall",   k, 32'(ifid_s[k]), 32'(e[k].ifid));
          chk("idex_stall",   k, 32'(idex_s[k]), 32'(e[k].idex));
          chk("idex_bubble",  k, 32'(bub_s[k]),  32'(e[k].bub));
          chk("exmem_stall",  k, 32'(exm_s[k]),  32'(e[k].exm));
          chk("hazard_vec",   k, 32'(hv_act),    32'(e[k].hv));
          chk("stall_cycles", k, 32'(sc_act),    32'(e[k].sc));
        end
      end
    end
  end

  initial begin : stimulus
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h35, 2'b10, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    idle(2);
    hz3(1'b0, 1'b0);
    idle(4);
    drive(1'b0, 1'b1, 8'h50, 2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h33, 2'b00, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h33, 2'b11, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    idle(3);
    hz3(1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    idle(4);
    hz3(1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle(3);
    hz3(1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 20; i++) hz3(1'b0, 1'b0);
    idle(2);
    hz3(1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h35, 2'b10, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 1500; i++) begin
      drive(1'b0 || ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1),
            4'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
